fp_div_arbiter: RTL and testbench

- Shares one division_floating unit among NREQ requesters using round-robin arbitration.
- Per transaction: grants one requester, latches its operands, pulses the divider's data_valid, waits for data_ready, then returns the result to the owning requester with a valid/ready handshake.
- Divide-by-zero is handled locally without using the divider; a watchdog aborts a hung divide.
- Sits between the FP ALU issue logic and the divider datapath.

---
 rtl/fp_div_arbiter.sv | 129 ++++++++++++
 tb/tb_fp_div_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one FP divider, with local divide-by-zero handling and a watchdog
module fp_div_arbiter #(
  parameter int XLEN    = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*XLEN-1:0] req_dividend,
  input  logic [NREQ*XLEN-1:0] req_divisor,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [XLEN-1:0]      resp_result,
  output logic                 resp_dbz,
  output logic                 resp_timeout,
  output logic [IDW-1:0]       resp_id,
  output logic [XLEN-1:0]      div_dividend,
  output logic [XLEN-1:0]      div_divisor,
  output logic                 div_data_valid,
  input  logic                 div_data_ready,
  input  logic [XLEN-1:0]      div_product,
  input  logic                 div_by_zero,
  output logic                 busy
);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [XLEN-1:0] QNAN = 32'h7FC00000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t          r_state;
  logic [IDW-1:0]  r_ptr, r_id;
  logic [WDW-1:0]  r_wd;
  logic [XLEN-1:0] r_a, r_b, r_res;
  logic            r_dbz, r_to, r_busy, r_div_valid;
  logic [NREQ-1:0] r_resp_valid;
  logic [IDW-1:0]  w_cand [NREQ];
  logic [IDW-1:0]  w_win;
  logic            w_any;
  logic [XLEN-1:0] w_a, w_b;
  logic            w_unused;
  assign w_unused = div_by_zero;
  always_comb
    for (int i = 0; i < NREQ; i++) w_cand[i] = IDW'((int'(r_ptr) + i) % NREQ);
  // descending scan so the candidate closest to r_ptr is the last to win
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[w_cand[i]]) begin
        w_win = w_cand[i];
        w_any = 1'b1;
      end
  end
  assign w_a            = req_dividend[w_win*XLEN +: XLEN];
  assign w_b            = req_divisor[w_win*XLEN +: XLEN];
  assign req_ready      = (r_state == IDLE && w_any) ? NREQ'(1) << w_win : '0;
  assign resp_valid     = r_resp_valid;
  assign resp_result    = r_res;
  assign resp_dbz       = r_dbz;
  assign resp_timeout   = r_to;
  assign resp_id        = r_id;
  assign div_dividend   = r_a;
  assign div_divisor    = r_b;
  assign div_data_valid = r_div_valid;
  assign busy           = r_busy;
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_wd         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_dbz        <= 1'b0;
      r_to         <= 1'b0;
      r_busy       <= 1'b0;
      r_div_valid  <= 1'b0;
      r_resp_valid <= '0;
    end else begin
      r_div_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_a    <= w_a;
          r_b    <= w_b;
          r_id   <= w_win;
          r_busy <= 1'b1;
          r_to   <= 1'b0;
          r_dbz  <= 1'b0;
          if (w_b[XLEN-2:0] == '0) begin
            r_state      <= RESP;
            r_dbz        <= 1'b1;
            r_res        <= (w_a[XLEN-2:0] == '0) ? QNAN : {w_a[XLEN-1] ^ w_b[XLEN-1], 8'hFF, 23'h0};
            r_resp_valid <= NREQ'(1) << w_win;
          end else begin
            r_state     <= ISSUE;
            r_div_valid <= 1'b1;
          end
        end
        ISSUE: begin
          r_wd    <= '0;
          r_state <= WAIT;
        end
        // the first WAIT cycle ignores div_data_ready to mask a stale level
        WAIT: if (r_wd != '0 && div_data_ready) begin
          r_res        <= div_product;
          r_dbz        <= 1'b0;
          r_to         <= 1'b0;
          r_state      <= RESP;
          r_resp_valid <= NREQ'(1) << r_id;
        end else if (r_wd == WDW'(TIMEOUT - 1)) begin
          r_res        <= QNAN;
          r_to         <= 1'b1;
          r_state      <= RESP;
          r_resp_valid <= NREQ'(1) << r_id;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
        RESP: if (resp_ready[r_id]) begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_resp_valid <= '0;
          r_ptr        <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: table vectors, reset/backpressure sequences and randomized transactions vs a reference model
module tb_fp_div_arbiter;
  localparam int T = 8;
  logic         CLK = 1'b0, rst = 1'b1;
  logic [3:0]   req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [127:0] req_dividend = '0, req_divisor = '0;
  logic [31:0]  resp_result, div_dividend, div_divisor, div_product = '0;
  logic         resp_dbz, resp_timeout, div_data_valid, busy;
  logic         div_data_ready = 1'b0, div_by_zero = 1'b0;
  logic [1:0]   resp_id;
  int n_chk = 0, n_fail = 0, m_ptr = 0, dlat = -1, dcnt = -1;
  typedef struct {
    logic [3:0] v; int id; logic [31:0] a, b, p; int lat, hold;
    logic [31:0] er; logic edbz, eto; int ecyc;
  } vec_t;
  vec_t tbl [11];

  always #5 CLK = ~CLK;

  fp_div_arbiter #(.XLEN(32), .NREQ(4), .IDW(2), .TIMEOUT(T)) dut (
    .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_result(resp_result), .resp_dbz(resp_dbz),
    .resp_timeout(resp_timeout), .resp_id(resp_id), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_data_valid(div_data_valid),
    .div_data_ready(div_data_ready), .div_product(div_product),
    .div_by_zero(div_by_zero), .busy(busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // divider model: lat>0 pulses ready lat cycles after the start pulse, 0 = stuck high, <0 = stuck low
  task automatic tick();
    @(posedge CLK);
    #1;
    if (dlat > 0) begin
      if (div_data_valid) dcnt = dlat;
      else if (dcnt >= 0) dcnt--;
      div_data_ready = (dcnt == 0);
    end else div_data_ready = (dlat == 0);
  endtask

  function automatic int ref_id(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    return -1;
  endfunction

  task automatic expect_of(input logic [31:0] a, b, p, input int lat,
                           output logic [31:0] er, output logic edbz, eto, output int ecyc);
    edbz = 1'b0; eto = 1'b0;
    if (b[30:0] == 31'h0) begin
      edbz = 1'b1; ecyc = 1;
      er = (a[30:0] == 31'h0) ? 32'h7FC00000 : {a[31] ^ b[31], 31'h7F800000};
    end else if (lat == 0 || (lat >= 2 && lat <= T)) begin
      er = p; ecyc = 2 + ((lat == 0) ? 2 : lat);
    end else begin
      er = 32'h7FC00000; eto = 1'b1; ecyc = 2 + T;
    end
  endtask

  task automatic run_txn(input logic [3:0] v, input int id, input logic [31:0] a, b, p,
                         input int lat, hold, input logic [31:0] er, input logic edbz, eto,
                         input int ecyc);
    int n, np;
    logic [3:0] oh;
    oh = 4'(1 << id);
    dlat = lat; dcnt = -1; div_data_ready = (lat == 0); div_product = p;
    for (int k = 0; k < 4; k++) begin
      req_dividend[k*32 +: 32] = (k == id) ? a : $urandom;
      req_divisor[k*32 +: 32]  = (k == id) ? b : $urandom;
    end
    req_valid = v;
    #1;
    chk("grant", req_ready, oh);
    n = 0; np = 0;
    do begin
      tick();
      n++;
      if (div_data_valid) np++;
      if (resp_valid == 4'h0) begin
        chk("no_grant_busy", req_ready, 0);
        chk("busy", busy, 1);
        chk("div_a", div_dividend, a);
        chk("div_b", div_divisor, b);
      end
    end while (resp_valid == 4'h0 && n < 20);
    chk("latency", n, ecyc);
    chk("issue_pulses", np, edbz ? 0 : 1);
    chk("resp_valid", resp_valid, oh);
    chk("resp_id", resp_id, id);
    chk("result", resp_result, er);
    chk("dbz", resp_dbz, edbz);
    chk("timeout", resp_timeout, eto);
    resp_ready = ~oh;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", resp_valid, oh);
      chk("hold_result", resp_result, er);
      chk("hold_flags", {resp_dbz, resp_timeout}, {edbz, eto});
    end
    resp_ready = 4'hF;
    tick();
    resp_ready = 4'h0;
    chk("accept_idle", {busy, resp_valid}, 0);
    m_ptr = (id + 1) % 4;
  endtask

  initial begin
    logic [3:0] v;
    logic [31:0] a, b, p, er;
    logic edbz, eto;
    int lat, id, ecyc;
    tbl[0]  = '{4'b0001, 0, 32'h40C00000, 32'h40000000, 32'h40400000, 5, 0, 32'h40400000, 1'b0, 1'b0, 7};
    tbl[1]  = '{4'b1111, 1, 32'h3F800000, 32'h40000000, 32'h3F000000, 3, 1, 32'h3F000000, 1'b0, 1'b0, 5};
    tbl[2]  = '{4'b1111, 2, 32'hBF800000, 32'h80000000, 32'h11111111, 3, 10, 32'h7F800000, 1'b1, 1'b0, 1};
    tbl[3]  = '{4'b1111, 3, 32'h00000000, 32'h00000000, 32'h22222222, 3, 0, 32'h7FC00000, 1'b1, 1'b0, 1};
    tbl[4]  = '{4'b1111, 0, 32'h41200000, 32'h40A00000, 32'h40000000, -1, 2, 32'h7FC00000, 1'b0, 1'b1, 10};
    tbl[5]  = '{4'b1010, 1, 32'h40800000, 32'h40000000, 32'h12345678, 0, 0, 32'h12345678, 1'b0, 1'b0, 4};
    tbl[6]  = '{4'b0010, 1, 32'h40800000, 32'h40000000, 32'h40000000, 1, 0, 32'h7FC00000, 1'b0, 1'b1, 10};
    tbl[7]  = '{4'b1001, 3, 32'h40490FDB, 32'h3F800000, 32'hC0490FDB, 8, 1, 32'hC0490FDB, 1'b0, 1'b0, 10};
    tbl[8]  = '{4'b0100, 2, 32'h3F800000, 32'h00000000, 32'h33333333, 2, 0, 32'h7F800000, 1'b1, 1'b0, 1};
    tbl[9]  = '{4'b0001, 0, 32'h80000000, 32'h00000000, 32'h44444444, 2, 0, 32'h7FC00000, 1'b1, 1'b0, 1};
    tbl[10] = '{4'b1111, 1, 32'hC0000000, 32'h3F800000, 32'hC0000000, 2, 0, 32'hC0000000, 1'b0, 1'b0, 4};
    tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", {req_ready, resp_valid, div_data_valid, busy, resp_dbz, resp_timeout, resp_id}, 0);
    chk("reset_result", resp_result, 0);
    for (int i = 0; i < 11; i++)
      run_txn(tbl[i].v, tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].lat, tbl[i].hold,
              tbl[i].er, tbl[i].edbz, tbl[i].eto, tbl[i].ecyc);
    // reset while a divide is pending: transaction is dropped and rr pointer returns to 0
    dlat = -1; div_data_ready = 1'b0;
    req_dividend = '0; req_divisor = '0;
    req_dividend[64 +: 32] = 32'h3F800000;
    req_divisor[64 +: 32]  = 32'h3F800000;
    req_valid = 4'b0100;
    tick(); tick(); tick();
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1; req_valid = 4'h0;
    tick();
    rst = 1'b0;
    chk("rst_wait_outputs", {req_ready, resp_valid, div_data_valid, busy, resp_dbz, resp_timeout, resp_id}, 0);
    chk("rst_wait_result", resp_result, 0);
    chk("rst_wait_div_a", div_dividend, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_resp_after_rst", resp_valid, 0);
    end
    m_ptr = 0;
    run_txn(4'hF, 0, 32'h40000000, 32'h40000000, 32'h3F800000, 3, 0, 32'h3F800000, 1'b0, 1'b0, 5);
    // randomized: the first 8 with all requesters active must rotate 0,1,2,3,0,1,2,3
    rst = 1'b1; tick(); rst = 1'b0; m_ptr = 0;
    for (int t = 0; t < 48; t++) begin
      v = (t < 8) ? 4'hF : 4'($urandom_range(1, 15));
      a = $urandom; b = $urandom; p = $urandom;
      if ($urandom_range(0, 3) == 0) b[30:0] = 31'h0;
      if ($urandom_range(0, 3) == 0) a[30:0] = 31'h0;
      lat = int'($urandom_range(0, 10)) - 1;
      id = (t < 8) ? t % 4 : ref_id(v);
      expect_of(a, b, p, lat, er, edbz, eto, ecyc);
      run_txn(v, id, a, b, p, lat, int'($urandom_range(0, 3)), er, edbz, eto, ecyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
